// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared types and constants for the PS/2 host transmitter and
//             the mouse receive path.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Host-to-device transmitter sequence states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } ps2_tx_state_t;

    // Start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    // Odd parity bit for a PS/2 data byte
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_sync_edge
//  Brief    : Two-flop synchronizer for one raw PS/2 line plus a falling-edge
//             detector on the synchronized value.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    // [0],[1] form the synchronizer, [2] holds the previous synced value.
    // Lines idle high, so everything resets to 1 to avoid a false edge.
    logic [2:0] sync_q;

    // Shift the raw line through the synchronizer and history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], i_line};
        end
    end

    assign o_sync = sync_q[1];
    assign o_fall = sync_q[2] & ~sync_q[1];

endmodule : ps2_sync_edge
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : PS/2 host-to-device command transmitter. Performs the
//             request-to-send sequence, clocks out one byte with odd parity
//             on device clock edges and checks the device ACK bit.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    // Bit counter value on the edge that places the stop bit
    localparam logic [3:0]       C_LAST_BIT = 4'(PS2_FRAME_BITS - 2);

    ps2_tx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [3:0]                    bit_q, bit_d;
    logic [PS2_FRAME_BITS-2:0]     shift_q, shift_d;
    logic                          clk_oe_q, clk_oe_d;
    logic                          dat_oe_q, dat_oe_d;
    logic                          busy_q, busy_d;

    logic                          w_sync_clk, w_clk_fall;
    logic                          w_sync_dat, w_unused_dat_fall;
    logic [CNT_W-1:0]              w_cnt_inc;

    ps2_sync_edge u_sync_clk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (i_ps2_clk),
        .o_sync (w_sync_clk),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (i_ps2_dat),
        .o_sync (w_sync_dat),
        .o_fall (w_unused_dat_fall)
    );

    // Shared cycle counter saturates instead of wrapping
    assign w_cnt_inc = (cnt_q == C_CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // Next-state and line-drive decisions for the transmit sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (i_valid) begin
                    state_d  = S_INHIBIT;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    shift_d  = {1'b1, ps2_odd_parity(i_data), i_data};
                end
            end
            S_INHIBIT: begin
                // Clock edges are ignored here: the host owns the clock line
                if (cnt_q >= C_INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                bit_d    = '0;
                cnt_d    = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                cnt_d = w_cnt_inc;
                if (cnt_q >= C_TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = S_ERROR;
                end else if (w_clk_fall) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[PS2_FRAME_BITS-2:1]};
                    bit_d    = bit_q + 1'b1;
                    if (bit_q == C_LAST_BIT) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = w_cnt_inc;
                if (cnt_q >= C_TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = S_ERROR;
                end else if (w_clk_fall) begin
                    state_d = w_sync_dat ? S_ERROR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = w_cnt_inc;
                if (cnt_q >= C_TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = S_ERROR;
                end else if (w_sync_clk && w_sync_dat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered line drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_ps2_clk_oe = clk_oe_q;
    assign o_ps2_dat_oe = dat_oe_q;
    assign o_busy       = busy_q;
    assign o_done       = (state_q == S_DONE);
    assign o_err        = (state_q == S_ERROR);

endmodule : ps2_host_tx
`default_nettype wire
